padder_stream: RTL and testbench
================================

# padder_stream

Parametrised, sequential Keccak/SHA-3 message padder. Takes a word-serial message, applies pad10*1 with a configurable domain-separation byte, and assembles rate-sized blocks for the permutation core. It sits between the host input port and the `f_permutation` input, generalising the single-word combinational padder to any word width, rate and domain.

## Interface
- `IN_W`, default 32: input word width in bits; multiple of 8, range 8..64.
- `RATE`, default 576: block width in bits; must be a multiple of `IN_W`.
- `DOMAIN`, default 8'h06: padding start byte. 8'h01 is Keccak, 8'h06 is SHA-3, 8'h1F is SHAKE.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low; clears all state.
- `in` input `IN_W`: message word; byte 0 is the most-significant byte.
- `in_ready` input 1: `in` is valid this cycle.
- `is_last` input 1: qualifies `in` as the final (possibly partial) word.
- `byte_num` input `$clog2(IN_W/8)` (min 1): count of valid bytes in the last word, 0..IN_W/8-1.
- `buffer_full` output 1: the block does not accept input.
- `out` output `RATE`: assembled block; the first word received lands in `out[RATE-1 -: IN_W]`.
- `out_ready` output 1: `out` holds a complete block.
- `f_ack` input 1: the consumer has taken `out`.

## Operation
- Let WPB = RATE/IN_W. A word counter `cnt` runs 0..WPB.
- A word is accepted when `in_ready && !buffer_full`. On accept: `out <= {out[RATE-IN_W-1:0], w}` and `cnt` increments.
- If `is_last=0`, w = `in`.
- If `is_last=1`, w is built as follows:
  - Bytes `< byte_num` are taken from `in`.
  - Byte `byte_num` is `DOMAIN`.
  - The remaining bytes are zero.
  - If this word is word WPB-1, its LSB byte is ORed with 8'h80. Example: `DOMAIN` in the last byte gives 8'h86.
- States:
  - ACCEPT: takes words. On a non-last word that makes `cnt==WPB`, go to FULL. On a last word: go to FULL if `cnt` reaches WPB, otherwise go to PAD.
  - PAD: shifts in one zero word per cycle. The word that completes the block has LSB byte 8'h80. When `cnt` reaches WPB, go to FULL.
  - FULL: `out_ready=1`. On `f_ack`, clear `cnt`. Go to ACCEPT if the message is not finished; go to DONE if the final block was just acknowledged.
  - DONE: idle. Leaves only on `reset`.
- Padding never spills into an extra block, because `byte_num <= IN_W/8-1` always leaves one free byte. A byte-aligned message ending on a word boundary is terminated with an extra `is_last`, `byte_num=0` word. That word may open a new block.
- `buffer_full = (state != ACCEPT)`.
- `out_ready = (state == FULL)`.
- `in_ready` is ignored while `buffer_full=1`.
- `f_ack` is ignored outside FULL.
- `byte_num` is ignored unless `is_last=1`.
- A `byte_num` value of IN_W/8 or more is illegal; the response is unspecified.

## Timing
- Reset values:
  - `out` = 0, `out_ready` = 0, `buffer_full` = 0.
  - State = ACCEPT, `cnt` = 0, finished flag = 0.
- Assertion of `reset` takes effect immediately and discards any partial block. Deassertion is synchronised externally.
- `out_ready` and `buffer_full` rise one cycle after the accepting edge of the block-completing word.
- If the last word lands at index k < WPB-1, PAD lasts WPB-1-k cycles. `out_ready` rises the cycle after the last pad word.
- `f_ack` in FULL:
  - `out_ready` falls one cycle later.
  - `buffer_full` falls in the same cycle unless entering DONE.
  - The next word can be accepted in the cycle after the ack.
- Throughput: one word per cycle. No combinational path from `in_ready` or `f_ack` to any output.

## Structure
- `sha3_pkg` holds `DOMAIN_KECCAK`, `DOMAIN_SHA3`, `DOMAIN_SHAKE`, `PAD_LAST_BYTE` (8'h80), the state enum, and rate constants (1152, 1088, 832, 576).
- One sub-module, `padder_word`: combinational `IN_W`-generic word padder with inputs `in`, `byte_num`, `last_in_block`, `pad_only`. The main module holds the FSM, counter and shift register.

## Test plan
- Defaults, empty message (`is_last=1`, `byte_num=0`, `in` = any value):
  - 17 PAD cycles, then `out_ready=1`.
  - `out[575:568]=8'h06`, `out[7:0]=8'h80`, all other bits 0.
  - `f_ack` puts the block in DONE with `buffer_full=1`.
- One word 0x11223344 with `is_last=1`, `byte_num=3`: `out[575:544]=32'h11223306`, `out[7:0]=8'h80`.
- 17 full words, then last word 0xAABBCCDD with `byte_num=3`: no PAD cycles, `out[31:0]=32'hAABBCC86`.
- 18 full words:
  - FULL holds; `in_ready` pulses are not accepted while `buffer_full=1`.
  - `f_ack` clears the block; then an `is_last`, `byte_num=0` word produces a second block beginning 8'h06.
- Async `reset` low mid-PAD (k=5): outputs go to zero immediately. After release, an empty message produces the same block as the first scenario.
- `IN_W=64`, `RATE=1088`, `DOMAIN=8'h1F`, last word with `byte_num=7` at index 16 (final word): LSB byte = 8'h9F.

Source files
------------

// File: rtl/sha3_pkg.sv
// Shared constants, state encoding and helpers for the SHA-3 message padder.
package sha3_pkg;

   localparam logic [7:0] DOMAIN_KECCAK = 8'h01;
   localparam logic [7:0] DOMAIN_SHA3   = 8'h06;
   localparam logic [7:0] DOMAIN_SHAKE  = 8'h1F;
   localparam logic [7:0] PAD_LAST_BYTE = 8'h80;

   localparam int RATE_1152 = 1152;
   localparam int RATE_1088 = 1088;
   localparam int RATE_832  = 832;
   localparam int RATE_576  = 576;

   typedef enum logic [1:0] {
      ST_ACCEPT = 2'd0,
      ST_PAD    = 2'd1,
      ST_FULL   = 2'd2,
      ST_DONE   = 2'd3
   } pad_state_t;

   // Width of the valid-byte count; never narrower than one bit.
   function automatic int bn_width(input int in_w);
      return (in_w > 8) ? $clog2(in_w / 8) : 1;
   endfunction

endpackage

// File: rtl/padder_word.sv
// Combinational pad10*1 word builder: keeps the valid bytes, inserts the
// domain byte, zero-fills, and sets the closing 0x80 bit on the block's last word.
module padder_word import sha3_pkg::*; #(
   parameter int         IN_W   = 32,
   parameter logic [7:0] DOMAIN = DOMAIN_SHA3,
   localparam int        BN_W   = bn_width(IN_W)
) (
   input  logic [IN_W-1:0] in,
   input  logic [BN_W-1:0] byte_num,
   input  logic            last_in_block,
   input  logic            pad_only,
   output logic [IN_W-1:0] out
);

   localparam int NB = IN_W / 8;

   always_comb begin
      out = '0;
      // Byte 0 sits in the most-significant position.
      for (int i = 0; i < NB; i++) begin
         if (!pad_only && i < int'(byte_num)) begin
            out[IN_W-1-8*i -: 8] = in[IN_W-1-8*i -: 8];
         end else if (!pad_only && i == int'(byte_num)) begin
            out[IN_W-1-8*i -: 8] = DOMAIN;
         end
      end
      if (last_in_block) begin
         out[7:0] = out[7:0] | PAD_LAST_BYTE;
      end
   end

endmodule

// File: rtl/padder_stream.sv
// Word-serial Keccak/SHA-3 padder: shifts message words into a rate-wide
// block, applies pad10*1 on the final word and hands complete blocks onward.
module padder_stream import sha3_pkg::*; #(
   parameter int         IN_W   = 32,
   parameter int         RATE   = 576,
   parameter logic [7:0] DOMAIN = DOMAIN_SHA3,
   localparam int        BN_W   = bn_width(IN_W)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [IN_W-1:0] in,
   input  logic            in_ready,
   input  logic            is_last,
   input  logic [BN_W-1:0] byte_num,
   output logic            buffer_full,
   output logic [RATE-1:0] out,
   output logic            out_ready,
   input  logic            f_ack,
   output pad_state_t      state_dbg
);

   localparam int               WPB      = RATE / IN_W;
   localparam int               CNT_W    = $clog2(WPB + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WPB - 1);

   // Handshake: a word moves when in_ready && !buffer_full at a rising edge;
   // a block moves when out_ready && f_ack at a rising edge.
   pad_state_t      state;
   logic [CNT_W-1:0] cnt;
   logic            finished;
   logic            last_in_block;
   logic            pad_only;
   logic [IN_W-1:0] pad_word;
   logic [IN_W-1:0] shift_word;
   logic [RATE-1:0] out_shifted;

   assign last_in_block = (cnt == CNT_LAST);
   assign pad_only      = (state == ST_PAD);

   padder_word #(
      .IN_W   (IN_W),
      .DOMAIN (DOMAIN)
   ) u_padder_word (
      .in            (in),
      .byte_num      (byte_num),
      .last_in_block (last_in_block),
      .pad_only      (pad_only),
      .out           (pad_word)
   );

   assign shift_word = (state == ST_ACCEPT && !is_last) ? in : pad_word;

   if (WPB == 1) begin : g_single
      assign out_shifted = shift_word;
   end else begin : g_multi
      assign out_shifted = {out[RATE-IN_W-1:0], shift_word};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= ST_ACCEPT;
         cnt      <= '0;
         finished <= 1'b0;
         out      <= '0;
      end else begin
         case (state)
            ST_ACCEPT: begin
               if (in_ready) begin
                  out <= out_shifted;
                  cnt <= cnt + CNT_W'(1);
                  if (is_last) begin
                     finished <= 1'b1;
                  end
                  if (last_in_block) begin
                     state <= ST_FULL;
                  end else if (is_last) begin
                     state <= ST_PAD;
                  end
               end
            end
            ST_PAD: begin
               out <= out_shifted;
               cnt <= cnt + CNT_W'(1);
               if (last_in_block) begin
                  state <= ST_FULL;
               end
            end
            ST_FULL: begin
               if (f_ack) begin
                  cnt   <= '0;
                  state <= finished ? ST_DONE : ST_ACCEPT;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Status flags decode straight from the state register, so no input
   // reaches an output combinationally.
   assign buffer_full = (state != ST_ACCEPT);
   assign out_ready   = (state == ST_FULL);
   assign state_dbg   = state;

endmodule

// File: tb/tb_padder_stream.sv
// Bench for padder_stream: byte-level reference model for the default
// configuration, directed scenarios, a 64-bit SHAKE instance, random messages.
module tb_padder_stream;
   import sha3_pkg::*;

   localparam int A_W    = 32;
   localparam int A_RATE = 576;
   localparam int A_WPB  = A_RATE / A_W;
   localparam int A_NB   = A_W / 8;
   localparam int B_W    = 64;
   localparam int B_RATE = 1088;
   localparam int VW     = 1088;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst_a, rst_b;
   logic [A_W-1:0]    a_in;
   logic              a_in_ready, a_is_last;
   logic [1:0]        a_byte_num;
   logic              a_buffer_full, a_out_ready;
   logic [A_RATE-1:0] a_out;
   logic              a_ack_man, a_ack_rnd, a_f_ack;
   pad_state_t        a_dbg;

   logic [B_W-1:0]    b_in;
   logic              b_in_ready, b_is_last;
   logic [2:0]        b_byte_num;
   logic              b_buffer_full, b_out_ready;
   logic [B_RATE-1:0] b_out;
   logic              b_f_ack;
   pad_state_t        b_dbg;

   assign a_f_ack = a_ack_man | a_ack_rnd;

   padder_stream u_dut_a (
      .clk         (clk),
      .reset       (rst_a),
      .in          (a_in),
      .in_ready    (a_in_ready),
      .is_last     (a_is_last),
      .byte_num    (a_byte_num),
      .buffer_full (a_buffer_full),
      .out         (a_out),
      .out_ready   (a_out_ready),
      .f_ack       (a_f_ack),
      .state_dbg   (a_dbg)
   );

   padder_stream #(
      .IN_W   (B_W),
      .RATE   (B_RATE),
      .DOMAIN (DOMAIN_SHAKE)
   ) u_dut_b (
      .clk         (clk),
      .reset       (rst_b),
      .in          (b_in),
      .in_ready    (b_in_ready),
      .is_last     (b_is_last),
      .byte_num    (b_byte_num),
      .buffer_full (b_buffer_full),
      .out         (b_out),
      .out_ready   (b_out_ready),
      .f_ack       (b_f_ack),
      .state_dbg   (b_dbg)
   );

   int n_checks = 0;
   int n_fail   = 0;

   function automatic void chk1(input string nm, input logic got, input logic exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0b exp=%0b", nm, got, exp);
      end
   endfunction

   function automatic void chk_v(input string nm, input logic [VW-1:0] got, input logic [VW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
      end
   endfunction

   function automatic void fail_now(input string nm);
      n_checks++;
      n_fail++;
      $display("FAIL %s got=timeout exp=event", nm);
   endfunction

   // Reference model: the block is a queue of bytes in arrival order.
   typedef enum int {M_ACC, M_PAD, M_FULL, M_DONE} model_st_t;
   model_st_t         m_st;
   int                m_words;
   bit                m_fin, m_took;
   logic [7:0]        byte_q[$];
   logic [A_RATE-1:0] exp_q[$];

   task automatic m_reset();
      m_st    = M_ACC;
      m_words = 0;
      m_fin   = 0;
      m_took  = 0;
      byte_q.delete();
      exp_q.delete();
   endtask

   task automatic m_close();
      logic [A_RATE-1:0] blk;
      blk = '0;
      for (int i = 0; i < A_RATE / 8; i++) blk[A_RATE-1-8*i -: 8] = byte_q[i];
      if (m_fin) blk[7:0] = blk[7:0] | 8'h80;
      exp_q.push_back(blk);
      m_st = M_FULL;
   endtask

   task automatic m_step();
      logic [7:0] b;
      m_took = 0;
      case (m_st)
         M_ACC: if (a_in_ready) begin
            m_took = 1;
            for (int i = 0; i < A_NB; i++) begin
               if (!a_is_last || i < int'(a_byte_num)) b = a_in[A_W-1-8*i -: 8];
               else if (i == int'(a_byte_num)) b = 8'h06;
               else b = 8'h00;
               byte_q.push_back(b);
            end
            m_words++;
            if (a_is_last) m_fin = 1;
            if (m_words == A_WPB) m_close();
            else if (a_is_last) m_st = M_PAD;
         end
         M_PAD: begin
            for (int i = 0; i < A_NB; i++) byte_q.push_back(8'h00);
            m_words++;
            if (m_words == A_WPB) m_close();
         end
         M_FULL: if (a_f_ack) begin
            m_words = 0;
            byte_q.delete();
            void'(exp_q.pop_front());
            m_st = m_fin ? M_DONE : M_ACC;
         end
         default: begin
         end
      endcase
   endtask

   initial begin
      m_reset();
      forever begin
         @(posedge clk or negedge rst_a);
         if (!rst_a) m_reset();
         else m_step();
      end
   end

   // Compare process: every falling edge, DUT A against the model.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_a) begin
            chk1("rst_out_ready", a_out_ready, 1'b0);
            chk1("rst_buffer_full", a_buffer_full, 1'b0);
            chk_v("rst_out", VW'(a_out), VW'(0));
         end else begin
            chk1("out_ready", a_out_ready, m_st == M_FULL);
            chk1("buffer_full", a_buffer_full, m_st != M_ACC);
            if (m_st == M_FULL && exp_q.size() > 0) chk_v("block", VW'(a_out), VW'(exp_q[0]));
         end
      end
   end

   bit rnd_en = 0;
   initial begin
      a_ack_rnd = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         a_ack_rnd = rnd_en && ($urandom_range(0, 2) == 0);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=running exp=finished");
      $fatal(1, "watchdog expired");
   end

   // Driver tasks start and end 1 time unit after a rising edge.
   task automatic send_a(input logic [A_W-1:0] d, input logic last, input logic [1:0] bn);
      int t = 0;
      a_in = d; a_is_last = last; a_byte_num = bn; a_in_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (m_took) break;
         t++;
         if (t > 300) begin
            fail_now("accept_timeout");
            break;
         end
      end
      a_in_ready = 1'b0;
      a_in       = $urandom();
      a_is_last  = 1'($urandom_range(0, 1));
      a_byte_num = 2'($urandom_range(0, 3));
   endtask

   task automatic wait_ready_a(output int n);
      n = 0;
      @(negedge clk);
      while (!a_out_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic ack_a();
      a_ack_man = 1'b1;
      @(posedge clk);
      #1;
      a_ack_man = 1'b0;
   endtask

   task automatic reset_a();
      rst_a = 1'b0;
      @(posedge clk);
      #1;
      rst_a = 1'b1;
      @(posedge clk);
      #1;
   endtask

   logic [A_RATE-1:0] e_empty;
   logic [B_W-1:0]    b_first, b_last;
   int                n;

   initial begin
      a_in = '0; a_in_ready = 0; a_is_last = 0; a_byte_num = '0; a_ack_man = 0;
      b_in = '0; b_in_ready = 0; b_is_last = 0; b_byte_num = '0; b_f_ack = 0;
      rst_a = 0; rst_b = 0;
      e_empty = '0;
      e_empty[575:568] = 8'h06;
      e_empty[7:0]     = 8'h80;
      repeat (2) @(posedge clk);
      #1;
      chk1("reset_out_ready", a_out_ready, 1'b0);
      chk1("reset_buffer_full", a_buffer_full, 1'b0);
      chk_v("reset_out", VW'(a_out), VW'(0));
      rst_a = 1; rst_b = 1;
      @(posedge clk);
      #1;

      // Empty message: 17 pad cycles, then DONE after the ack.
      send_a(32'hDEADBEEF, 1'b1, 2'd0);
      wait_ready_a(n);
      chk_v("empty_pad_cycles", VW'(n), VW'(17));
      chk_v("empty_block", VW'(a_out), VW'(e_empty));
      ack_a();
      chk1("done_buffer_full", a_buffer_full, 1'b1);
      chk1("done_out_ready", a_out_ready, 1'b0);

      // Single partial word.
      reset_a();
      send_a(32'h11223344, 1'b1, 2'd3);
      wait_ready_a(n);
      chk_v("one_word_pad_cycles", VW'(n), VW'(17));
      chk_v("one_word_head", VW'(a_out[575:544]), VW'(32'h11223306));
      chk_v("one_word_tail", VW'(a_out[7:0]), VW'(8'h80));
      ack_a();

      // Last word lands in the final slot of the block.
      reset_a();
      repeat (17) send_a($urandom(), 1'b0, 2'($urandom_range(0, 3)));
      send_a(32'hAABBCCDD, 1'b1, 2'd3);
      wait_ready_a(n);
      chk_v("final_slot_pad_cycles", VW'(n), VW'(0));
      chk_v("final_slot_word", VW'(a_out[31:0]), VW'(32'hAABBCC86));
      ack_a();

      // Full block held while in_ready pulses, then terminator block.
      reset_a();
      repeat (18) send_a($urandom(), 1'b0, 2'($urandom_range(0, 3)));
      wait_ready_a(n);
      chk_v("full_block_pad_cycles", VW'(n), VW'(0));
      a_in = $urandom(); a_is_last = 1'b0; a_in_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk1("held_buffer_full", a_buffer_full, 1'b1);
      a_in_ready = 1'b0;
      ack_a();
      chk1("after_ack_buffer_full", a_buffer_full, 1'b0);
      send_a($urandom(), 1'b1, 2'd0);
      wait_ready_a(n);
      chk_v("term_pad_cycles", VW'(n), VW'(17));
      chk_v("term_head", VW'(a_out[575:568]), VW'(8'h06));
      ack_a();

      // Asynchronous reset in the middle of padding.
      reset_a();
      repeat (5) send_a($urandom(), 1'b0, 2'($urandom_range(0, 3)));
      send_a($urandom(), 1'b1, 2'd2);
      repeat (4) @(posedge clk);
      #2;
      rst_a = 1'b0;
      #1;
      chk_v("async_rst_out", VW'(a_out), VW'(0));
      chk1("async_rst_out_ready", a_out_ready, 1'b0);
      chk1("async_rst_buffer_full", a_buffer_full, 1'b0);
      @(posedge clk);
      #1;
      rst_a = 1'b1;
      @(posedge clk);
      #1;
      send_a($urandom(), 1'b1, 2'd0);
      wait_ready_a(n);
      chk_v("post_rst_pad_cycles", VW'(n), VW'(17));
      chk_v("post_rst_block", VW'(a_out), VW'(e_empty));
      ack_a();

      // 64-bit SHAKE instance: last word in final slot with 7 valid bytes.
      for (int i = 0; i < 16; i++) begin
         b_in = {$urandom(), $urandom()};
         if (i == 0) b_first = b_in;
         b_in_ready = 1'b1; b_is_last = 1'b0; b_byte_num = 3'($urandom_range(0, 7));
         @(posedge clk);
         #1;
      end
      b_in_ready = 1'b0;
      chk1("b_not_ready_yet", b_out_ready, 1'b0);
      b_last = {$urandom(), $urandom()};
      b_in = b_last; b_in_ready = 1'b1; b_is_last = 1'b1; b_byte_num = 3'd7;
      @(posedge clk);
      #1;
      b_in_ready = 1'b0;
      chk1("b_out_ready", b_out_ready, 1'b1);
      chk1("b_buffer_full", b_buffer_full, 1'b1);
      chk_v("b_lsb_byte", VW'(b_out[7:0]), VW'(8'h9F));
      chk_v("b_last_data", VW'(b_out[63:8]), VW'(b_last[63:8]));
      chk_v("b_first_word", VW'(b_out[1087:1024]), VW'(b_first));

      // Random messages with random gaps and random acknowledges.
      for (int msg = 0; msg < 30; msg++) begin
         int nw;
         int t;
         reset_a();
         rnd_en = 1;
         nw = $urandom_range(0, 40);
         for (int w = 0; w < nw; w++) begin
            repeat ($urandom_range(0, 2)) begin
               @(posedge clk);
               #1;
            end
            send_a($urandom(), 1'b0, 2'($urandom_range(0, 3)));
         end
         send_a($urandom(), 1'b1, 2'($urandom_range(0, 3)));
         t = 0;
         while (m_st != M_DONE && t < 500) begin
            @(posedge clk);
            #1;
            t++;
         end
         if (m_st != M_DONE) fail_now("rand_done_timeout");
         rnd_en = 0;
         @(posedge clk);
         #1;
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
